// File: rtl/clock_pkg.sv
// Shared types and display codes for the 12-hour clock sequencer.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } clk_mode_t;

   localparam logic [6:0] AM    = 7'd10;
   localparam logic [6:0] PM    = 7'd11;
   localparam logic [6:0] BLANK = 7'b1000000;

endpackage

// File: rtl/btn_edge_rpt.sv
// Button front end: 2-flop synchronizer, rising-edge pulse and optional
// hold-then-repeat pulse train. clr drops the current press and gates the pulse.
module btn_edge_rpt #(
   parameter int HOLD_CYC = 50_000_000,
   parameter int RPT_CYC  = 20_000_000,
   parameter bit RPT_EN   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic clr,
   output logic pulse
);

   localparam int MAXC = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
   localparam int CW   = $clog2(MAXC);

   logic          s1, s2, prev;
   logic          armed;
   logic [CW-1:0] cnt;
   logic          edge_p, rpt_p;

   assign edge_p = s2 & ~prev;
   assign rpt_p  = RPT_EN & armed & s2 & (cnt == '0);
   assign pulse  = ~clr & (edge_p | rpt_p);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         prev  <= 1'b0;
         armed <= 1'b0;
         cnt   <= '0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         prev <= s2;
         // A cleared press stays disarmed until the button is released and pressed again
         if (clr || !s2 || !RPT_EN) begin
            armed <= 1'b0;
            cnt   <= '0;
         end else if (edge_p) begin
            armed <= 1'b1;
            cnt   <= CW'(HOLD_CYC - 1);
         end else if (armed) begin
            if (cnt == '0)
               cnt <= CW'(RPT_CYC - 1);
            else
               cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/clock_time_ctrl.sv
// Clock sequencer: 1 Hz prescaler, cascaded enable pulses, mode FSM with
// button-driven setting and blink strobe for the digits being set.
//
//  state   | meaning
//  RUN     | time keeping, tick drives sec/min/hr enables, buttons adv ignored
//  SET_HR  | adv press/repeat pulses hr_enb, blink active
//  SET_MIN | adv press/repeat pulses min_enb, blink active; exit clears seconds
module clock_time_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int HOLD_CYC  = 50_000_000,
   parameter int RPT_CYC   = 20_000_000,
   parameter int BLINK_CYC = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_adv,
   input  logic sec_tc,
   input  logic min_tc,
   output logic sec_enb,
   output logic min_enb,
   output logic hr_enb,
   output logic sec_clr,
   output logic set_hr,
   output logic set_min,
   output logic blink
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_CYC);
   localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_CYC - 1);

   clk_mode_t     mode;
   logic [PW-1:0] presc;
   logic [BW-1:0] blink_cnt;
   logic          mode_p, adv_p;

   btn_edge_rpt #(.HOLD_CYC(2), .RPT_CYC(2), .RPT_EN(1'b0)) u_mode_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .clr   (1'b0),
      .pulse (mode_p)
   );

   btn_edge_rpt #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .RPT_EN(1'b1)) u_adv_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_adv),
      .clr   (mode_p),
      .pulse (adv_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode      <= RUN;
         presc     <= '0;
         blink_cnt <= '0;
         sec_enb   <= 1'b0;
         min_enb   <= 1'b0;
         hr_enb    <= 1'b0;
         sec_clr   <= 1'b0;
         set_hr    <= 1'b0;
         set_min   <= 1'b0;
         blink     <= 1'b1;
      end else begin
         sec_enb <= 1'b0;
         min_enb <= 1'b0;
         hr_enb  <= 1'b0;
         sec_clr <= 1'b0;
         if (mode_p) begin
            // Any mode change discards a pending tick and restarts blink on
            presc     <= '0;
            blink     <= 1'b1;
            blink_cnt <= BLINK_LD;
            case (mode)
               RUN: begin
                  mode   <= SET_HR;
                  set_hr <= 1'b1;
               end
               SET_HR: begin
                  mode    <= SET_MIN;
                  set_hr  <= 1'b0;
                  set_min <= 1'b1;
               end
               default: begin
                  mode    <= RUN;
                  set_hr  <= 1'b0;
                  set_min <= 1'b0;
                  sec_clr <= 1'b1;
               end
            endcase
         end else begin
            if (mode == RUN) begin
               if (presc == PRESC_TC) begin
                  presc   <= '0;
                  sec_enb <= 1'b1;
                  min_enb <= sec_tc;
                  hr_enb  <= sec_tc & min_tc;
               end else begin
                  presc <= presc + PW'(1);
               end
            end else begin
               if (adv_p) begin
                  hr_enb  <= (mode == SET_HR);
                  min_enb <= (mode == SET_MIN);
               end
               if (blink_cnt == '0) begin
                  blink     <= ~blink;
                  blink_cnt <= BLINK_LD;
               end else begin
                  blink_cnt <= blink_cnt - BW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl with small timing parameters.
module tb_clock_time_ctrl;

   logic clk = 1'b0;
   logic rst, btn_mode, btn_adv, sec_tc, min_tc;
   logic sec_enb, min_enb, hr_enb, sec_clr, set_hr, set_min, blink;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int         c;
      logic [3:0] v;
   } exp_t;
   exp_t q[$];

   clock_time_ctrl #(.TICK_DIV(10), .HOLD_CYC(8), .RPT_CYC(4), .BLINK_CYC(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_adv  (btn_adv),
      .sec_tc   (sec_tc),
      .min_tc   (min_tc),
      .sec_enb  (sec_enb),
      .min_enb  (min_enb),
      .hr_enb   (hr_enb),
      .sec_clr  (sec_clr),
      .set_hr   (set_hr),
      .set_min  (set_min),
      .blink    (blink)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse vector order: {sec_enb, min_enb, hr_enb, sec_clr}
   task automatic expect_pulse(input int c, input logic [3:0] v);
      exp_t e;
      e.c = c;
      e.v = v;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic act, input logic req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] v;
      exp_t e;
      v = {sec_enb, min_enb, hr_enb, sec_clr};
      while (q.size() > 0 && q[0].c < cyc) begin
         e = q.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL missed_pulse: expected %b at cycle %0d, not seen", e.v, e.c);
      end
      if (v != 4'b0000) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", v, cyc);
         end else begin
            e = q.pop_front();
            if (e.c != cyc || e.v != v) begin
               n_fail++;
               $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                        v, cyc, e.v, e.c);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      int r, m, n, s, h, r2;
      rst = 1'b1; btn_mode = 1'b0; btn_adv = 1'b0; sec_tc = 1'b0; min_tc = 1'b0;
      wait_until(3);
      chk("rst_sec_enb", sec_enb, 1'b0);
      chk("rst_min_enb", min_enb, 1'b0);
      chk("rst_hr_enb",  hr_enb,  1'b0);
      chk("rst_sec_clr", sec_clr, 1'b0);
      chk("rst_set_hr",  set_hr,  1'b0);
      chk("rst_set_min", set_min, 1'b0);
      chk("rst_blink",   blink,   1'b1);
      rst = 1'b0;
      r = cyc;

      // RUN ticks with carry patterns
      expect_pulse(r + 10, 4'b1000);
      expect_pulse(r + 20, 4'b1000);
      expect_pulse(r + 30, 4'b1100);
      expect_pulse(r + 40, 4'b1110);
      wait_until(r + 25); sec_tc = 1'b1;
      wait_until(r + 35); min_tc = 1'b1;
      wait_until(r + 42); btn_mode = 1'b1;
      wait_until(r + 44); chk("set_hr_early", set_hr, 1'b0); btn_mode = 1'b0;
      wait_until(r + 45); chk("set_hr_entry", set_hr, 1'b1);
      sec_tc = 1'b0; min_tc = 1'b0;
      m = cyc;

      // SET_HR: blink cadence and single tap
      wait_until(m + 4);  chk("blink_hr_on",   blink, 1'b1);
      wait_until(m + 5);  chk("blink_hr_off",  blink, 1'b0);
      wait_until(m + 10); chk("blink_hr_on2",  blink, 1'b1);
      wait_until(m + 12); btn_adv = 1'b1;
      expect_pulse(m + 15, 4'b0010);
      wait_until(m + 14); btn_adv = 1'b0;

      // SET_MIN: held advance with auto-repeat
      wait_until(m + 100); btn_mode = 1'b1;
      wait_until(m + 102); btn_mode = 1'b0;
      wait_until(m + 103);
      n = cyc;
      chk("set_min_entry", set_min, 1'b1);
      chk("set_hr_exit",   set_hr,  1'b0);
      wait_until(n + 10); btn_adv = 1'b1;
      expect_pulse(n + 13, 4'b0100);
      for (int k = 0; k < 6; k++) expect_pulse(n + 21 + 4 * k, 4'b0100);
      wait_until(n + 40); btn_adv = 1'b0;

      // Back to RUN: seconds clear and prescaler restart
      wait_until(n + 60); btn_mode = 1'b1;
      s = n + 63;
      expect_pulse(s,      4'b0001);
      expect_pulse(s + 10, 4'b1000);
      expect_pulse(s + 20, 4'b1000);
      wait_until(n + 62); btn_mode = 1'b0;
      wait_until(s);
      chk("set_min_exit", set_min, 1'b0);
      chk("blink_run",    blink,   1'b1);
      wait_until(s + 7); chk("blink_run2", blink, 1'b1);

      // Async reset mid-SET_HR with advance held
      wait_until(s + 22); btn_mode = 1'b1;
      wait_until(s + 24); btn_mode = 1'b0;
      h = s + 25;
      wait_until(h); chk("set_hr_again", set_hr, 1'b1);
      wait_until(h + 5); btn_adv = 1'b1;
      expect_pulse(h + 8,  4'b0010);
      expect_pulse(h + 16, 4'b0010);
      wait_until(h + 17);
      chk("blink_before_rst", blink, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_rst_set_hr", set_hr, 1'b0);
      chk("async_rst_blink",  blink,  1'b1);
      chk("async_rst_hr_enb", hr_enb, 1'b0);
      wait_until(h + 20);
      rst = 1'b0;
      r2 = cyc;
      expect_pulse(r2 + 10, 4'b1000);
      expect_pulse(r2 + 20, 4'b1000);
      wait_until(r2 + 5); btn_adv = 1'b0;
      wait_until(r2 + 25);
      chk("post_rst_set_hr", set_hr, 1'b0);
      chk("post_rst_set_min", set_min, 1'b0);
      chk("scoreboard_empty", q.size() == 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
